conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Producer side of the 3x3 convolution datapath.
- Accepts a raster-order 8-bit pixel stream, buffers the two previous image rows, and emits 3x3 windows on the same interface the convolution kernel consumes: data_line0/1/2 (3 pixels each) qualified by vbit_o.
- Produces only "valid" windows, i.e. (IMG_W-2) x (IMG_H-2) windows per frame, with no backpressure (the kernel is a fixed pipeline).

Parameters:
- IMG_W, 28, pixels per row (>=3).
- IMG_H, 28, rows per frame (>=3).
- CW, 5, column counter width, must satisfy 2^CW >= IMG_W.
- RW, 5, row counter width, must satisfy 2^RW >= IMG_H.

Ports:
- clk  in  1  clock. One clock domain; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- frame_start_i  in  1  synchronous restart; forces the position to row 0, column 0.
- pix_i  in  8  input pixel, opaque 8-bit fixed-point value.
- pix_vld_i  in  1  pix_i is valid this cycle. Accepted unconditionally.
- data_line0  out  24  top window row (row r-2).
- data_line1  out  24  middle window row (row r-1).
- data_line2  out  24  bottom window row (row r).
- vbit_o  out  1  window outputs valid. Single-cycle qualifier.
- frame_done_o  out  1  one-cycle pulse on the last window of a frame.

Behaviour:
- **Reset.** rstn low clears col/row counters, window registers, data_line0/1/2 (24'h0), vbit_o (0) and frame_done_o (0). Line-buffer RAM contents are not reset and are don't-care; they are never exposed before being overwritten.
- **Storage.**
  - Two line buffers, lb_a (row r-1) and lb_b (row r-2), each IMG_W x 8 bits.
  - 3x3 window register set.
- **Per accepted pixel at position (r,c):**
  - read a = lb_a[c] and b = lb_b[c];
  - write lb_b[c] <= a and lb_a[c] <= pix_i;
  - shift the window one column left; the new right column is {b, a, pix_i} for lines 0/1/2.
- **Byte order within each line.**
  - [7:0] = column c-2 (leftmost).
  - [15:8] = column c-1.
  - [23:16] = column c.
- **Latency.**
  - vbit_o asserts exactly 1 cycle after a pixel is accepted with r>=2 and c>=2.
  - data_line0/1/2 update in the same cycle as vbit_o.
- **No pixel.** When pix_vld_i=0: vbit_o=0 next cycle, and window registers and outputs hold. Arbitrary gaps are allowed.
- **Counters.**
  - c increments per accepted pixel.
  - At c=IMG_W-1: c wraps to 0 and r increments.
  - At r=IMG_H-1, c=IMG_W-1: r wraps to 0.
- **frame_done_o.** Asserts in the same cycle as the vbit_o for window (IMG_H-1, IMG_W-1).
- **Row wrap.** Windows at c=0 and c=1 hold previous-row columns but are suppressed (vbit_o=0). No window ever straddles rows.
- **Frame wrap.**
  - Rows 0 and 1 of the next frame produce no windows, so stale line-buffer data is never emitted.
  - Back-to-back frames need no idle cycle.
- **frame_start_i.**
  - Takes effect in the cycle it is asserted.
  - If pix_vld_i is also high, that pixel is treated as (0,0) and the counters advance to (0,1).
  - If pix_vld_i is low, the counters go to (0,0).
  - An in-flight vbit_o from the previous cycle still completes. No frame_done_o is generated for the aborted frame.
- **Reset mid-frame.** Behaves as a fresh power-up. The first window appears only after row 2, col 2 of the new stream.
- **Outputs.** No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. **Basic 4x4 frame.** IMG_W=4, IMG_H=4, pixels 0x00..0x0F continuous, one per cycle.
   - Exactly 4 vbit_o pulses, appearing the cycle after pixels 0x0A, 0x0B, 0x0E, 0x0F.
   - First window: line0=24'h020100, line1=24'h060504, line2=24'h0A0908.
   - Last window: line0=24'h070605, line1=24'h0B0A09, line2=24'h0F0E0D, with frame_done_o=1 in that cycle only.
2. **Gapped input.** Same frame with pix_vld_i toggling 1/0 every cycle.
   - Identical window values and order.
   - vbit_o never high on consecutive cycles; outputs hold during gaps.
3. **Back-to-back frames.** Two 4x4 frames (second frame pixels 0x10..0x1F), no idle cycle.
   - 8 windows total.
   - Second frame's first window: 24'h121110 / 24'h161514 / 24'h1A1918.
   - No window emitted during second-frame rows 0-1.
4. **frame_start_i mid-frame.** Assert frame_start_i with pix_vld_i=1 at pixel 0x05, then continue with pixels 0x06..
   - No frame_done_o for the aborted frame.
   - Next vbit_o only after 10 further pixels (position r2,c2).
   - Window data comes solely from the restarted stream.
5. **Async reset mid-frame.** Pull rstn low between pixels 0x09 and 0x0A.
   - Outputs go to 0 immediately.
   - After release, behaviour matches scenario 1 from pixel 0x00.
6. **Default parameters.** IMG_W=28, IMG_H=28 with random pixels.
   - 676 windows.
   - Each window matches a software 3x3 extraction reference.
   - Exactly one frame_done_o.

Source files
------------

// File: rtl/conv_window_gen.sv
// Builds 3x3 windows from a raster pixel stream using two row line buffers; window outputs registered.
// Latency: one cycle from the accepted pixel to vbit_o. No backpressure: every valid pixel is consumed.
module conv_window_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CW    = 5,
    parameter int RW    = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        frame_start_i,
    input  logic [7:0]  pix_i,
    input  logic        pix_vld_i,
    output logic [23:0] data_line0,
    output logic [23:0] data_line1,
    output logic [23:0] data_line2,
    output logic        vbit_o,
    output logic        frame_done_o
);

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic [23:0]   win0_q, win0_d, win1_q, win1_d, win2_q, win2_d;
    logic [23:0]   line0_q, line0_d, line1_q, line1_d, line2_q, line2_d;
    logic          vbit_q, vbit_d, done_q, done_d;
    logic          emit;
    logic [7:0]    rd_a, rd_b;

    // lb_a holds row r-1, lb_b holds row r-2; contents are never reset
    logic [7:0]    lb_a [2**CW];
    logic [7:0]    lb_b [2**CW];

    always_comb begin
        col_cur = frame_start_i ? '0 : col_q;
        row_cur = frame_start_i ? '0 : row_q;
        rd_a    = lb_a[col_cur];
        rd_b    = lb_b[col_cur];
        col_d   = col_cur;
        row_d   = row_cur;
        win0_d  = win0_q;
        win1_d  = win1_q;
        win2_d  = win2_q;
        emit    = 1'b0;
        done_d  = 1'b0;
        if (pix_vld_i) begin
            // newest column enters at [23:16], oldest drops out of [7:0]
            win0_d = {rd_b,  win0_q[23:8]};
            win1_d = {rd_a,  win1_q[23:8]};
            win2_d = {pix_i, win2_q[23:8]};
            emit   = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
            done_d = emit && (row_cur == RW'(IMG_H - 1)) && (col_cur == CW'(IMG_W - 1));
            if (col_cur == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_cur == RW'(IMG_H - 1)) ? '0 : row_cur + RW'(1);
            end else begin
                col_d = col_cur + CW'(1);
            end
        end
        vbit_d  = emit;
        line0_d = emit ? win0_d : line0_q;
        line1_d = emit ? win1_d : line1_q;
        line2_d = emit ? win2_d : line2_q;
    end

    always_ff @(posedge clk) begin
        if (pix_vld_i) begin
            lb_b[col_cur] <= rd_a;
            lb_a[col_cur] <= pix_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q   <= '0;
            row_q   <= '0;
            win0_q  <= '0;
            win1_q  <= '0;
            win2_q  <= '0;
            line0_q <= '0;
            line1_q <= '0;
            line2_q <= '0;
            vbit_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win0_q  <= win0_d;
            win1_q  <= win1_d;
            win2_q  <= win2_d;
            line0_q <= line0_d;
            line1_q <= line1_d;
            line2_q <= line2_d;
            vbit_q  <= vbit_d;
            done_q  <= done_d;
        end
    end

    assign data_line0   = line0_q;
    assign data_line1   = line1_q;
    assign data_line2   = line2_q;
    assign vbit_o       = vbit_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 4x4 instance for the directed scenarios and a 28x28 instance for random frames.
module tb_conv_window_gen;

    typedef struct packed {
        logic [23:0] l0;
        logic [23:0] l1;
        logic [23:0] l2;
        logic        done;
        logic        vbit;
    } out_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        frame_start_i = 1'b0;
    logic [7:0]  pix_i = 8'h00;
    logic        pix_vld_i = 1'b0;

    logic [23:0] s_l0, s_l1, s_l2, b_l0, b_l1, b_l2;
    logic        s_vb, s_fd, b_vb, b_fd;
    out_t        got_s, got_b;

    int checks = 0;
    int errors = 0;

    // reference model: captured image per geometry, expected registered outputs
    logic [7:0] img [2][28][28];
    int         mr [2];
    int         mc [2];
    out_t       ex [2];
    out_t       win_ref [$];

    always #5 clk = ~clk;

    conv_window_gen #(.IMG_W(4), .IMG_H(4), .CW(2), .RW(2)) u_small (
        .clk(clk), .rstn(rstn), .frame_start_i(frame_start_i), .pix_i(pix_i), .pix_vld_i(pix_vld_i),
        .data_line0(s_l0), .data_line1(s_l1), .data_line2(s_l2), .vbit_o(s_vb), .frame_done_o(s_fd)
    );

    conv_window_gen u_big (
        .clk(clk), .rstn(rstn), .frame_start_i(frame_start_i), .pix_i(pix_i), .pix_vld_i(pix_vld_i),
        .data_line0(b_l0), .data_line1(b_l1), .data_line2(b_l2), .vbit_o(b_vb), .frame_done_o(b_fd)
    );

    assign got_s = {s_l0, s_l1, s_l2, s_fd, s_vb};
    assign got_b = {b_l0, b_l1, b_l2, b_fd, b_vb};

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            mr[g] = 0;
            mc[g] = 0;
            ex[g] = '0;
        end
    endtask

    task automatic model_step(input logic [7:0] p, input bit v, input bit fs);
        for (int g = 0; g < 2; g++) begin
            int w = (g == 0) ? 4 : 28;
            int h = (g == 0) ? 4 : 28;
            int r, c;
            ex[g].vbit = 1'b0;
            ex[g].done = 1'b0;
            if (fs) begin
                mr[g] = 0;
                mc[g] = 0;
            end
            if (v) begin
                r = mr[g];
                c = mc[g];
                img[g][r][c] = p;
                if (r >= 2 && c >= 2) begin
                    ex[g].vbit = 1'b1;
                    ex[g].l0   = {img[g][r-2][c], img[g][r-2][c-1], img[g][r-2][c-2]};
                    ex[g].l1   = {img[g][r-1][c], img[g][r-1][c-1], img[g][r-1][c-2]};
                    ex[g].l2   = {img[g][r][c],   img[g][r][c-1],   img[g][r][c-2]};
                    ex[g].done = (r == h - 1) && (c == w - 1);
                end
                mc[g] = c + 1;
                if (mc[g] == w) begin
                    mc[g] = 0;
                    mr[g] = (r + 1 == h) ? 0 : r + 1;
                end
            end
        end
    endtask

    // drive one cycle of stimulus; leaves time at 1 unit past the sampling edge
    task automatic drive(input logic [7:0] p, input bit v, input bit fs);
        pix_i         = p;
        pix_vld_i     = v;
        frame_start_i = fs;
        @(posedge clk);
        #1;
        model_step(p, v, fs);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        pix_vld_i = 1'b0;
        frame_start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (got_s !== '0) begin errors++; $display("FAIL reset_small got=%h exp=0", got_s); end
        checks++;
        if (got_b !== '0) begin errors++; $display("FAIL reset_big got=%h exp=0", got_b); end
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        int   nwin = 0;
        int   ndone = 0;
        out_t first = '0, last = '0, want;
        for (int i = 0; i < 17; i++) begin
            drive(8'(i), i < 16, 1'b0);
            checks++;
            if (got_s !== ex[0]) begin errors++; $display("FAIL basic_cyc%0d got=%h exp=%h", i, got_s, ex[0]); end
            checks++;
            if ((got_s.vbit === 1'b1) != (i inside {10, 11, 14, 15})) begin
                errors++; $display("FAIL basic_vbit_pos pix%0d got=%b", i, got_s.vbit);
            end
            if (got_s.vbit === 1'b1) begin
                if (nwin == 0) first = got_s;
                last = got_s;
                win_ref.push_back(got_s);
                nwin++;
            end
            if (got_s.done === 1'b1) ndone++;
        end
        checks++;
        if (nwin != 4) begin errors++; $display("FAIL basic_count got=%0d exp=4", nwin); end
        want = {24'h020100, 24'h060504, 24'h0A0908, 1'b0, 1'b1};
        checks++;
        if (first !== want) begin errors++; $display("FAIL basic_first got=%h exp=%h", first, want); end
        want = {24'h070605, 24'h0B0A09, 24'h0F0E0D, 1'b1, 1'b1};
        checks++;
        if (last !== want) begin errors++; $display("FAIL basic_last got=%h exp=%h", last, want); end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", ndone); end
    endtask

    task automatic test_gapped();
        int nwin = 0;
        bit prev = 1'b0;
        for (int i = 0; i < 34; i++) begin
            bit v = (i % 2 == 0) && (i < 32);
            drive(v ? 8'(i / 2) : 8'($urandom), v, 1'b0);
            checks++;
            if (got_s !== ex[0]) begin errors++; $display("FAIL gapped_cyc%0d got=%h exp=%h", i, got_s, ex[0]); end
            checks++;
            if (prev && got_s.vbit === 1'b1) begin errors++; $display("FAIL gapped_consecutive cyc%0d got=1 exp=0", i); end
            prev = (got_s.vbit === 1'b1);
            if (got_s.vbit === 1'b1) begin
                checks++;
                if (nwin >= win_ref.size() || got_s !== win_ref[nwin]) begin
                    errors++; $display("FAIL gapped_window%0d got=%h", nwin, got_s);
                end
                nwin++;
            end
        end
        checks++;
        if (nwin != 4) begin errors++; $display("FAIL gapped_count got=%0d exp=4", nwin); end
    endtask

    task automatic test_back_to_back();
        int   nwin = 0;
        out_t want, fifth = '0;
        for (int i = 0; i < 32; i++) begin
            drive(8'(i), 1'b1, 1'b0);
            checks++;
            if (got_s !== ex[0]) begin errors++; $display("FAIL b2b_cyc%0d got=%h exp=%h", i, got_s, ex[0]); end
            if (i >= 16 && i < 24) begin
                checks++;
                if (got_s.vbit !== 1'b0) begin errors++; $display("FAIL b2b_stale pix%0d got=1 exp=0", i); end
            end
            if (got_s.vbit === 1'b1) begin
                if (nwin == 4) fifth = got_s;
                nwin++;
            end
        end
        checks++;
        if (nwin != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", nwin); end
        want = {24'h121110, 24'h161514, 24'h1A1918, 1'b0, 1'b1};
        checks++;
        if (fifth !== want) begin errors++; $display("FAIL b2b_second_first got=%h exp=%h", fifth, want); end
    endtask

    task automatic test_frame_start();
        int   ndone = 0;
        int   first_pix = -1;
        out_t first = '0, want;
        for (int i = 0; i < 20; i++) begin
            drive(8'(i), 1'b1, i == 5);
            checks++;
            if (got_s !== ex[0]) begin errors++; $display("FAIL fstart_cyc%0d got=%h exp=%h", i, got_s, ex[0]); end
            if (got_s.done === 1'b1) ndone++;
            if (got_s.vbit === 1'b1 && first_pix < 0) begin
                first_pix = i;
                first = got_s;
            end
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL fstart_abort_done got=%0d exp=0", ndone); end
        checks++;
        if (first_pix != 15) begin errors++; $display("FAIL fstart_first_pos got=%0d exp=15", first_pix); end
        want = {24'h070605, 24'h0B0A09, 24'h0F0E0D, 1'b0, 1'b1};
        checks++;
        if (first !== want) begin errors++; $display("FAIL fstart_first_win got=%h exp=%h", first, want); end
        // restart with no pixel, then a full frame from (0,0)
        ndone = 0;
        for (int i = 0; i < 17; i++) begin
            drive(i == 0 ? 8'hEE : 8'(8'h40 + i - 1), i != 0, i == 0);
            checks++;
            if (got_s !== ex[0]) begin errors++; $display("FAIL fstart_idle_cyc%0d got=%h exp=%h", i, got_s, ex[0]); end
            if (got_s.done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL fstart_idle_done got=%0d exp=1", ndone); end
    endtask

    task automatic test_async_reset();
        int nwin = 0;
        for (int i = 0; i < 10; i++) drive(8'(i), 1'b1, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        checks++;
        if (got_s !== '0) begin errors++; $display("FAIL arst_immediate got=%h exp=0", got_s); end
        pix_vld_i = 1'b0;
        @(posedge clk);
        #3;
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(8'(i), 1'b1, 1'b0);
            checks++;
            if (got_s !== ex[0]) begin errors++; $display("FAIL arst_cyc%0d got=%h exp=%h", i, got_s, ex[0]); end
            if (got_s.vbit === 1'b1) begin
                checks++;
                if (nwin >= win_ref.size() || got_s !== win_ref[nwin]) begin
                    errors++; $display("FAIL arst_window%0d got=%h", nwin, got_s);
                end
                nwin++;
            end
        end
        checks++;
        if (nwin != 4) begin errors++; $display("FAIL arst_count got=%0d exp=4", nwin); end
    endtask

    task automatic test_default();
        int accepted = 0;
        int nwin = 0;
        int ndone = 0;
        int cyc = 0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rstn = 1'b1;
        while ((accepted < 784 || cyc < 800) && cyc < 4000) begin
            bit v = (accepted < 784) && ($urandom_range(3) != 0);
            drive(8'($urandom), v, 1'b0);
            if (v) accepted++;
            cyc++;
            checks++;
            if (got_b !== ex[1]) begin errors++; $display("FAIL default_cyc%0d got=%h exp=%h", cyc, got_b, ex[1]); end
            if (got_b.vbit === 1'b1) nwin++;
            if (got_b.done === 1'b1) ndone++;
        end
        checks++;
        if (accepted != 784) begin errors++; $display("FAIL default_budget got=%0d exp=784", accepted); end
        checks++;
        if (nwin != 676) begin errors++; $display("FAIL default_count got=%0d exp=676", nwin); end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL default_done got=%0d exp=1", ndone); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back();
        test_frame_start();
        test_async_reset();
        test_default();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
